// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit common-anode seven-segment scan controller with frame-synchronous content load.
// Define SCAN_BLANK_EN to blank the anodes for the first BLANK_CYC cycles of every digit slot.
module seg_scan_driver #(
  parameter int DIV_CNT   = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  mask_in,
  input  logic [7:0]  dp_in,
  output logic [3:0]  code,
  output logic [7:0]  an,
  output logic        dp_n,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = $clog2(DIV_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CNT - 1);

  if (DIV_CNT < 2) begin : g_bad_div
    $error("seg_scan_driver: DIV_CNT must be at least 2");
  end
  if (BLANK_CYC < 1 || BLANK_CYC >= DIV_CNT) begin : g_bad_blank
    $error("seg_scan_driver: BLANK_CYC must satisfy 1 <= BLANK_CYC < DIV_CNT");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          tick, wrap;

  logic [31:0]   stage_data_q, stage_data_d;
  logic [7:0]    stage_mask_q, stage_mask_d;
  logic [7:0]    stage_dp_q, stage_dp_d;
  logic          pending_q, pending_d;

  logic [31:0]   data_sh_q, data_sh_d;
  logic [7:0]    mask_sh_q, mask_sh_d;
  logic [7:0]    dp_sh_q, dp_sh_d;

  logic [3:0]    code_q, code_d;
  logic [7:0]    an_q, an_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_done_q;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    wrap  = tick && (idx_q == 3'd7);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? idx_q + 3'd1 : idx_q;
  end

  // A load coinciding with the wrap bypasses staging so it is shown in the very next frame.
  always_comb begin
    stage_data_d = stage_data_q;
    stage_mask_d = stage_mask_q;
    stage_dp_d   = stage_dp_q;
    pending_d    = pending_q;
    data_sh_d    = data_sh_q;
    mask_sh_d    = mask_sh_q;
    dp_sh_d      = dp_sh_q;

    if (load) begin
      stage_data_d = data_in;
      stage_mask_d = mask_in;
      stage_dp_d   = dp_in;
      pending_d    = 1'b1;
    end

    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        data_sh_d = data_in;
        mask_sh_d = mask_in;
        dp_sh_d   = dp_in;
      end else if (pending_q) begin
        data_sh_d = stage_data_q;
        mask_sh_d = stage_mask_q;
        dp_sh_d   = stage_dp_q;
      end
    end
  end

  // Outputs are registered from next-state values so a slot change appears on the tick edge.
  always_comb begin
    code_d = data_sh_d[{idx_d, 2'b00} +: 4];
    an_d   = 8'hFF;
    if (mask_sh_d[idx_d]) begin
      an_d[idx_d] = 1'b0;
    end
    dp_n_d = ~(dp_sh_d[idx_d] & mask_sh_d[idx_d]);
`ifdef SCAN_BLANK_EN
    if (cnt_d < CW'(BLANK_CYC)) begin
      an_d   = 8'hFF;
      dp_n_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      stage_data_q <= 32'h0;
      stage_mask_q <= 8'h00;
      stage_dp_q   <= 8'h00;
      pending_q    <= 1'b0;
      data_sh_q    <= 32'h0;
      mask_sh_q    <= 8'h00;
      dp_sh_q      <= 8'h00;
      code_q       <= 4'h0;
      an_q         <= 8'hFF;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stage_data_q <= stage_data_d;
      stage_mask_q <= stage_mask_d;
      stage_dp_q   <= stage_dp_d;
      pending_q    <= pending_d;
      data_sh_q    <= data_sh_d;
      mask_sh_q    <= mask_sh_d;
      dp_sh_q      <= dp_sh_d;
      code_q       <= code_d;
      an_q         <= an_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= wrap;
    end
  end

  assign code       = code_q;
  assign an         = an_q;
  assign dp_n       = dp_n_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
